wave_phase_accum: RTL and testbench
===================================

WAVE_PHASE_ACCUM -- requirements
Module: wave_phase_accum

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- SIZE_ACC, 16: phase accumulator and tuning-word width.
- SIZE_PHASE, 12: phase word and offset width.
- SIZE_ADDR, 10: quarter-wave LUT address width.
REQ-002 Parameter rule SHALL be SIZE_PHASE = SIZE_ADDR + 2 and SIZE_ACC >= SIZE_PHASE; elaboration SHALL fail otherwise.
REQ-003 Ports SHALL be, as name, direction, width, meaning:
- i_clk, in, 1: the single clock.
- i_rst, in, 1: synchronous active-high reset.
- i_en, in, 1: run enable (wave mode).
- i_tick, in, 1: sample strobe.
- i_clear, in, 1: accumulator clear strobe.
- i_fcw, in, SIZE_ACC: unsigned frequency control word.
- i_phase_offset, in, SIZE_PHASE: phase offset from the phase-adjust controller.
- o_valid, out, 1: one-cycle sample-ready pulse.
- o_addr, out, SIZE_ADDR: quarter-wave sine LUT address.
- o_negate, out, 1: sine sign (1 = negate LUT value).
- o_saw, out, SIZE_PHASE: sawtooth.
- o_tri, out, SIZE_PHASE-1: triangle.
- o_square, out, 1: square.
REQ-004 There SHALL be one clock and one synchronous active-high reset, i_rst; no other clock or reset.

Function
REQ-005 The accumulator acc SHALL update only on a rising edge of i_clk, with priority i_rst, then i_clear, then (i_en & i_tick).
REQ-006 On (i_en & i_tick) with i_clear=0, acc SHALL become (acc + i_fcw) mod 2^SIZE_ACC; wrap-around is silent.
REQ-007 On i_clear=1, acc SHALL become 0 regardless of i_tick or i_en, and no sample SHALL be launched that cycle.
REQ-008 Stage 1: on a launching cycle (i_en & i_tick & ~i_clear), the block SHALL register p = (acc[SIZE_ACC-1 -: SIZE_PHASE] + i_phase_offset) mod 2^SIZE_PHASE.
- acc here is the value before that cycle's update.
- i_phase_offset here is the value sampled that cycle.
- The stage-1 valid flag SHALL be set on that cycle and cleared on every other cycle.
REQ-009 Stage 2 SHALL register the outputs from p when the stage-1 valid flag is 1, and hold all outputs otherwise. Let q = p[SIZE_PHASE-1:SIZE_PHASE-2] and L = p[SIZE_ADDR-1:0].
- o_addr SHALL be L when q[0]=0, else bitwise ~L.
- o_negate SHALL be q[1].
- o_saw SHALL be p.
- o_square SHALL be ~p[SIZE_PHASE-1].
- o_tri SHALL be p[SIZE_PHASE-2:0] when p[SIZE_PHASE-1]=0, else bitwise ~p[SIZE_PHASE-2:0].
REQ-010 o_valid SHALL pulse high for exactly one cycle, 2 cycles after the launching edge. Latency is fixed at 2, and throughput is one sample per cycle with i_tick held high.
REQ-011 i_en=0 SHALL freeze acc, launch no samples, and let any in-flight sample complete.
REQ-012 i_clear SHALL NOT flush an already-launched stage-1 sample; that sample SHALL still emerge on o_valid.
REQ-013 Changing i_fcw or i_phase_offset SHALL take effect on the next launching cycle only, without glitching held outputs.
REQ-014 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-015 While i_rst=1 at a clock edge, the following SHALL all become 0 on that edge: acc, p, the stage-1 valid flag, o_valid, o_addr, o_negate, o_saw and o_tri.
REQ-016 o_square SHALL reset to 0.
REQ-017 A reset asserted mid-pipeline SHALL discard in-flight samples; no o_valid SHALL follow the reset edge until a new launch.
REQ-018 The first launch SHALL be possible on the first edge after i_rst deasserts.

Verification
Default parameters apply to all scenarios.
REQ-019 Reset: hold i_rst 3 cycles with i_tick=1 and i_fcw=0x1234 -> all outputs stay 0 and no o_valid appears; the first o_valid appears 2 cycles after the first post-reset tick.
REQ-020 Ramp: i_fcw=0x0100, offset 0, i_tick=1 continuously -> o_saw sequence 0x000, 0x010, 0x020, ... with o_valid high every cycle from the 3rd edge.
REQ-021 Wrap: i_fcw=0x8000, offset 0, three ticks -> o_saw 0x000, 0x800, 0x000. For the 0x800 sample: o_negate=1, o_addr=0x000, o_square=0, o_tri=0x7FF.
REQ-022 Offset and fold:
- acc=0, offset 0x400 -> o_addr=0x3FF, o_negate=0, o_tri=0x400, o_square=1.
- acc top bits 0x600, offset 0xC00 -> o_saw=0x200.
REQ-023 Clear and tick together: assert i_clear with i_tick=1 one cycle after a launch -> the earlier sample still emerges, no sample is launched that cycle, and the next tick yields o_saw equal to the offset.
REQ-024 Enable: drop i_en for 5 cycles with i_tick=1 -> no new o_valid after the in-flight sample, outputs hold, and acc is unchanged on re-enable.

Source files
------------

// File: rtl/wave_phase_accum.sv
// Phase accumulator feeding a two-stage waveform generator: quarter-wave sine LUT
// address/sign, sawtooth, triangle and square, fixed two-edge latency.
module wave_phase_accum #(
    parameter int SIZE_ACC   = 16,
    parameter int SIZE_PHASE = 12,
    parameter int SIZE_ADDR  = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_tick,
    input  logic                  i_clear,
    input  logic [SIZE_ACC-1:0]   i_fcw,
    input  logic [SIZE_PHASE-1:0] i_phase_offset,
    output logic                  o_valid,
    output logic [SIZE_ADDR-1:0]  o_addr,
    output logic                  o_negate,
    output logic [SIZE_PHASE-1:0] o_saw,
    output logic [SIZE_PHASE-2:0] o_tri,
    output logic                  o_square
);

    generate
        if (SIZE_PHASE != SIZE_ADDR + 2 || SIZE_ACC < SIZE_PHASE) begin : g_bad_params
            $error("wave_phase_accum: need SIZE_PHASE == SIZE_ADDR+2 and SIZE_ACC >= SIZE_PHASE");
        end
    endgenerate

    logic [SIZE_ACC-1:0]   acc_q, acc_d;
    logic [SIZE_PHASE-1:0] p_q, p_d;
    logic                  v1_q, v1_d;
    logic                  valid_q, valid_d;
    logic [SIZE_ADDR-1:0]  addr_q, addr_d;
    logic                  neg_q, neg_d;
    logic [SIZE_PHASE-1:0] saw_q, saw_d;
    logic [SIZE_PHASE-2:0] tri_q, tri_d;
    logic                  sq_q, sq_d;
    logic                  launch;

    assign launch = i_en & i_tick & ~i_clear;

    // Stage 1 samples the pre-update accumulator so the first launch after clear/reset yields the offset.
    always_comb begin
        acc_d = acc_q;
        p_d   = p_q;
        v1_d  = launch;
        if (i_clear) begin
            acc_d = '0;
        end else if (launch) begin
            acc_d = acc_q + i_fcw;
        end
        if (launch) begin
            p_d = acc_q[SIZE_ACC-1 -: SIZE_PHASE] + i_phase_offset;
        end
    end

    // Quadrants 1 and 3 read the quarter-wave table backwards; the upper half is negated.
    always_comb begin
        valid_d = v1_q;
        addr_d  = addr_q;
        neg_d   = neg_q;
        saw_d   = saw_q;
        tri_d   = tri_q;
        sq_d    = sq_q;
        if (v1_q) begin
            addr_d = p_q[SIZE_PHASE-2] ? ~p_q[SIZE_ADDR-1:0] : p_q[SIZE_ADDR-1:0];
            neg_d  = p_q[SIZE_PHASE-1];
            saw_d  = p_q;
            tri_d  = p_q[SIZE_PHASE-1] ? ~p_q[SIZE_PHASE-2:0] : p_q[SIZE_PHASE-2:0];
            sq_d   = ~p_q[SIZE_PHASE-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q   <= '0;
            p_q     <= '0;
            v1_q    <= 1'b0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            neg_q   <= 1'b0;
            saw_q   <= '0;
            tri_q   <= '0;
            sq_q    <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            p_q     <= p_d;
            v1_q    <= v1_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            neg_q   <= neg_d;
            saw_q   <= saw_d;
            tri_q   <= tri_d;
            sq_q    <= sq_d;
        end
    end

    assign o_valid  = valid_q;
    assign o_addr   = addr_q;
    assign o_negate = neg_q;
    assign o_saw    = saw_q;
    assign o_tri    = tri_q;
    assign o_square = sq_q;

endmodule

// File: tb/tb_wave_phase_accum.sv
// Randomized and directed stimulus for wave_phase_accum; an arithmetic reference model
// queues expected samples and a monitor checks them as o_valid appears.
module tb_wave_phase_accum;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_en = 1'b0;
    logic        i_tick = 1'b0;
    logic        i_clear = 1'b0;
    logic [15:0] i_fcw = '0;
    logic [11:0] i_phase_offset = '0;
    logic        o_valid;
    logic [9:0]  o_addr;
    logic        o_negate;
    logic [11:0] o_saw;
    logic [10:0] o_tri;
    logic        o_square;

    wave_phase_accum dut (
        .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .i_tick(i_tick), .i_clear(i_clear),
        .i_fcw(i_fcw), .i_phase_offset(i_phase_offset), .o_valid(o_valid),
        .o_addr(o_addr), .o_negate(o_negate), .o_saw(o_saw), .o_tri(o_tri),
        .o_square(o_square)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int unsigned addr;
        int unsigned neg;
        int unsigned saw;
        int unsigned tri_w;
        int unsigned sq;
    } exp_t;

    exp_t        sb[$];
    exp_t        last;
    int          cyc = 0;
    int          nchk = 0;
    int          npass = 0;
    bit          done = 0;
    int unsigned acc_m = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int unsigned act, input int unsigned want);
        nchk++;
        if (act == want) npass++;
        else $display("FAIL %s at cycle %0d: got 0x%0h want 0x%0h", name, cyc, act, want);
    endtask

    // Expected outputs straight from the phase value: quadrant fold, half-wave sign, tri mirror.
    function automatic exp_t model(input int unsigned p, input int due);
        exp_t e;
        e.due   = due;
        e.saw   = p;
        e.neg   = (p >= 2048) ? 1 : 0;
        e.sq    = (p < 2048) ? 1 : 0;
        e.addr  = ((p % 2048) >= 1024) ? 1023 - (p % 1024) : (p % 1024);
        e.tri_w = (p < 2048) ? p : 4095 - p;
        return e;
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e.due = 0; e.addr = 0; e.neg = 0; e.saw = 0; e.tri_w = 0; e.sq = 0;
        return e;
    endfunction

    task automatic step(input bit rst, input bit en, input bit tick, input bit clr,
                        input int unsigned fcw, input int unsigned off);
        @(negedge clk);
        i_rst = rst; i_en = en; i_tick = tick; i_clear = clr;
        i_fcw = fcw[15:0]; i_phase_offset = off[11:0];
        if (rst) begin
            acc_m = 0;
            sb.delete();
        end else begin
            if (en && tick && !clr) begin
                sb.push_back(model(((acc_m >> 4) + off) % 4096, cyc + 2));
                acc_m = (acc_m + fcw) % 65536;
            end
            if (clr) acc_m = 0;
        end
    endtask

    task automatic cmp_outs(input string tag, input exp_t e);
        chk({tag, "_addr"}, o_addr, e.addr);
        chk({tag, "_neg"}, o_negate, e.neg);
        chk({tag, "_saw"}, o_saw, e.saw);
        chk({tag, "_tri"}, o_tri, e.tri_w);
        chk({tag, "_square"}, o_square, e.sq);
    endtask

    initial begin
        exp_t e;
        last = zero_exp();
        while (!done) begin
            @(posedge clk);
            #1;
            if (i_rst) begin
                last = zero_exp();
                chk("rst_valid", o_valid, 0);
                cmp_outs("rst", last);
            end else if (o_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("latency", cyc, e.due);
                    cmp_outs("sample", e);
                    last = e;
                end
            end else begin
                cmp_outs("hold", last);
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    chk("missing_valid", 0, 1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        // Reset held with tick active, then first launch on the first free edge.
        repeat (3) step(1, 1, 1, 0, 16'h1234, 0);
        repeat (4) step(0, 1, 1, 0, 16'h1234, 0);
        // Ramp
        step(1, 1, 1, 0, 16'h0100, 0);
        repeat (20) step(0, 1, 1, 0, 16'h0100, 0);
        // Wrap
        step(1, 0, 0, 0, 0, 0);
        repeat (3) step(0, 1, 1, 0, 16'h8000, 0);
        repeat (3) step(0, 1, 0, 0, 16'h8000, 0);
        // Offset and fold
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 12'h400);
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 16'h6000, 0);
        step(0, 1, 1, 0, 0, 12'hC00);
        repeat (3) step(0, 1, 0, 0, 0, 0);
        // Clear together with tick, one cycle after a launch
        step(0, 1, 1, 0, 16'h0100, 12'h123);
        step(0, 1, 1, 1, 16'h0100, 12'h123);
        step(0, 1, 1, 0, 16'h0100, 12'h123);
        repeat (3) step(0, 1, 0, 0, 16'h0100, 12'h123);
        // Enable dropped for 5 cycles with tick high
        repeat (3) step(0, 1, 1, 0, 16'h0340, 12'h010);
        repeat (5) step(0, 0, 1, 0, 16'h0340, 12'h010);
        repeat (3) step(0, 1, 1, 0, 16'h0340, 12'h010);
        // Reset mid-pipeline discards in-flight samples
        step(0, 1, 1, 0, 16'h0777, 0);
        step(0, 1, 1, 0, 16'h0777, 0);
        step(1, 1, 1, 0, 16'h0777, 0);
        repeat (3) step(0, 1, 1, 0, 16'h0777, 0);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) != 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                 $urandom_range(0, 65535), $urandom_range(0, 4095));
        end
        repeat (5) step(0, 0, 0, 0, 0, 0);
        done = 1;
        @(posedge clk);
        #2;
        chk("drain_pending", sb.size(), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
